// File: rtl/spi_mem_target_if.sv
// SPI bus between the application master and the memory target.
// cpol/cpha ride along with the bus because both ends must agree on them.
interface spi_mem_target_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic cpol;
  logic cpha;
  logic miso;
  logic miso_oe;

  modport master (output sclk, cs_n, mosi, cpol, cpha, input miso, miso_oe);
  modport slave  (input sclk, cs_n, mosi, cpol, cpha, output miso, miso_oe);
endinterface

// File: rtl/spi_mem_target.sv
// Flash-style SPI target: opcode, 24-bit address, data bytes against a local
// byte memory. SPI inputs are oversampled on clk, which must run >= 8x sclk.
module spi_mem_target #(
  parameter int ADDR_BITS = 8,
  parameter int CLK_SYNC  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_mem_target_if.slave      bus,
  output logic                 wel,
  output logic                 busy,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 cmd_err
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

  localparam logic [7:0]           OP_WREN  = 8'h06;
  localparam logic [7:0]           OP_WRITE = 8'h02;
  localparam logic [7:0]           OP_READ  = 8'h03;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  state_t                 state;
  logic [CLK_SYNC-1:0]    sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s, sclk_d, cs_d;
  logic                   rise, fall, lead, trail, sample, shift, cs_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             sh_in;
  logic [7:0]             byte_nxt, sh_out;
  logic [ADDR_BITS-1:0]   addr, addr_nxt;
  logic [1:0]             abyte;
  logic                   is_rd, miso_q;
  logic [7:0]             mem [0:(1<<ADDR_BITS)-1];

  // cs_n chain clears low so a reset mid-transaction never looks like a fresh
  // cs_n fall; the target waits for cs_n to go high and low again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[CLK_SYNC-2:0], bus.sclk};
      cs_sync   <= {cs_sync[CLK_SYNC-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[CLK_SYNC-2:0], bus.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s   = sclk_sync[CLK_SYNC-1];
  assign cs_s     = cs_sync[CLK_SYNC-1];
  assign mosi_s   = mosi_sync[CLK_SYNC-1];
  assign rise     = sclk_s & ~sclk_d;
  assign fall     = ~sclk_s & sclk_d;
  assign lead     = bus.cpol ? fall : rise;
  assign trail    = bus.cpol ? rise : fall;
  assign sample   = bus.cpha ? trail : lead;
  assign shift    = bus.cpha ? lead : trail;
  assign cs_fall  = cs_d & ~cs_s;
  assign byte_nxt = {sh_in, mosi_s};
  // Only the low ADDR_BITS of the 24-bit address survive the shift.
  assign addr_nxt = ADDR_BITS'({addr, byte_nxt});

  assign bus.miso    = miso_q;
  assign bus.miso_oe = (state == RDATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      sh_in    <= '0;
      sh_out   <= '0;
      addr     <= '0;
      abyte    <= '0;
      is_rd    <= 1'b0;
      miso_q   <= 1'b0;
      wel      <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cmd_err  <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      cmd_err  <= 1'b0;
      busy     <= ~cs_s;
      if (cs_s) begin
        // cs_n high beats any coincident sample edge; partial byte is dropped
        if (state == WDATA) wel <= 1'b0;
        state   <= IDLE;
        bit_cnt <= '0;
        sh_in   <= '0;
        miso_q  <= 1'b0;
      end else if (cs_fall) begin
        state   <= CMD;
        bit_cnt <= '0;
        sh_in   <= '0;
        abyte   <= '0;
      end else if (state != IDLE) begin
        if (sample) begin
          bit_cnt <= bit_cnt + 3'd1;
          sh_in   <= byte_nxt[6:0];
          if (bit_cnt == 3'd7) begin
            case (state)
              CMD: begin
                case (byte_nxt)
                  OP_WREN: begin
                    wel   <= 1'b1;
                    state <= IGNORE;
                  end
                  OP_WRITE: begin
                    if (wel) begin
                      is_rd <= 1'b0;
                      state <= ADDR;
                    end else begin
                      cmd_err <= 1'b1;
                      state   <= IGNORE;
                    end
                  end
                  OP_READ: begin
                    is_rd <= 1'b1;
                    state <= ADDR;
                  end
                  default: begin
                    cmd_err <= 1'b1;
                    state   <= IGNORE;
                  end
                endcase
              end
              ADDR: begin
                addr  <= addr_nxt;
                abyte <= abyte + 2'd1;
                if (abyte == 2'd2) begin
                  if (is_rd) begin
                    state  <= RDATA;
                    sh_out <= mem[addr_nxt];
                    addr   <= addr_nxt + ADDR_ONE;
                  end else begin
                    state <= WDATA;
                  end
                end
              end
              WDATA: begin
                wr_valid <= 1'b1;
                wr_addr  <= addr;
                wr_data  <= byte_nxt;
                addr     <= addr + ADDR_ONE;
              end
              RDATA: begin
                sh_out <= mem[addr];
                addr   <= addr + ADDR_ONE;
              end
              default: ;
            endcase
          end
        end
        // bit_cnt is the index of the next bit the master will sample
        if (shift && state == RDATA) miso_q <= sh_out[~bit_cnt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_valid) mem[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_spi_mem_target.sv
// Drives whole SPI transactions and checks them against a byte-level model
// of the command set (opcode, big-endian address, wrapping data bytes).
module tb_spi_mem_target;
  localparam int H = 80;  // sclk half period, 8 clk

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wel, busy, wr_valid, cmd_err;
  logic [7:0] wr_addr, wr_data;

  spi_mem_target_if bus();

  spi_mem_target #(.ADDR_BITS(8), .CLK_SYNC(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .wel(wel), .busy(busy),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;

  logic [7:0] mem_m [256];
  bit         mem_v [256];
  bit         wel_m;
  wr_t        wq[$];
  int         err_pend;
  logic [7:0] tx_q[$];
  logic [7:0] rx_b [16];
  logic [7:0] exp_rd [16];
  bit         exp_rv [16];
  bit         rd_txn;
  int         checks = 0;
  int         passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic load(input logic [63:0] v, input int n);
    tx_q.delete();
    for (int k = n - 1; k >= 0; k--) tx_q.push_back(v[k*8 +: 8]);
  endtask

  task automatic mode(input int m);
    bus.cpol = m[1];
    bus.cpha = m[0];
  endtask

  // Byte-level prediction: only fully transferred bytes before any reset count.
  task automatic predict(input int nbits, input int rst_at);
    int         eb, full;
    logic [7:0] a;
    eb = (rst_at >= 0) ? rst_at : nbits;
    full = eb / 8;
    rd_txn = 1'b0;
    for (int k = 0; k < 16; k++) exp_rv[k] = 1'b0;
    if (full >= 1) begin
      a = (full >= 4) ? 8'({tx_q[1], tx_q[2], tx_q[3]} % 24'd256) : 8'h00;
      case (tx_q[0])
        8'h06: wel_m = 1'b1;
        8'h02: begin
          if (!wel_m) err_pend++;
          else if (full >= 4) begin
            for (int k = 4; k < full; k++) begin
              wq.push_back('{a: a, d: tx_q[k]});
              mem_m[a] = tx_q[k];
              mem_v[a] = 1'b1;
              a++;
            end
            wel_m = 1'b0;
          end
        end
        8'h03: begin
          if (full >= 4) begin
            rd_txn = 1'b1;
            for (int k = 4; k < full; k++) begin
              exp_rd[k] = mem_m[a];
              exp_rv[k] = mem_v[a];
              a++;
            end
          end
        end
        default: err_pend++;
      endcase
    end
    if (rst_at >= 0) wel_m = 1'b0;
  endtask

  task automatic xfer(input int nbits, input int rst_at);
    logic [7:0] sh, rxs;
    logic       b;
    bit         exp_oe;
    predict(nbits, rst_at);
    rxs = '0;
    for (int k = 0; k < 16; k++) rx_b[k] = '0;
    bus.sclk = bus.cpol;
    #(H);
    bus.cs_n = 1'b0;
    #(H);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #30;
        check("rst_wel", wel, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_miso", bus.miso, 0);
        check("rst_miso_oe", bus.miso_oe, 0);
        rst = 1'b0;
        #20;
      end
      sh = tx_q[i/8];
      b  = sh[7 - (i % 8)];
      if (!bus.cpha) begin
        bus.mosi = b;
        #(H);
      end else begin
        bus.sclk = ~bus.cpol;
        bus.mosi = b;
        #(H);
      end
      // master's sample point, just before the sample edge
      exp_oe = rd_txn && i >= 32 && (rst_at < 0 || i < rst_at);
      check("miso_oe", bus.miso_oe, exp_oe);
      if (i == 0) check("busy", busy, 1);
      rxs = {rxs[6:0], bus.miso};
      if (i % 8 == 7) begin
        rx_b[i/8] = rxs;
        if (exp_oe && exp_rv[i/8]) check("rd_byte", rxs, exp_rd[i/8]);
      end
      if (!bus.cpha) begin
        bus.sclk = ~bus.cpol;
        #(H);
        bus.sclk = bus.cpol;
      end else begin
        bus.sclk = bus.cpol;
        #(H);
      end
    end
    #(H);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    #(4*H);
    check("wr_drain", wq.size(), 0);
    check("err_drain", err_pend, 0);
    check("wel", wel, wel_m);
    check("busy_idle", busy, 0);
  endtask

  // Per-cycle compare of DUT events against the model's expectations.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (!bus.miso_oe) check("miso_quiet", bus.miso, 0);
      if (wr_valid) begin
        check("wr_expected", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          check("wr_addr", wr_addr, e.a);
          check("wr_data", wr_data, e.d);
        end
      end
      if (cmd_err) begin
        check("cmd_err_expected", 32'(err_pend > 0), 1);
        if (err_pend > 0) err_pend--;
      end
    end
  end

  initial begin
    logic [7:0] op, a;
    int         kind, nd, nb;
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    wel_m = 1'b0;
    err_pend = 0;
    for (int k = 0; k < 256; k++) mem_v[k] = 1'b0;
    #43;
    check("init_wel", wel, 0);
    check("init_busy", busy, 0);
    check("init_wr_valid", wr_valid, 0);
    check("init_wr_addr", wr_addr, 0);
    check("init_wr_data", wr_data, 0);
    check("init_cmd_err", cmd_err, 0);
    check("init_miso", bus.miso, 0);
    check("init_miso_oe", bus.miso_oe, 0);
    rst = 1'b0;
    #(4*H);

    // mode 0 write
    mode(0);
    load(64'h06, 1); xfer(8, -1);
    check("lit_wel_set", wel, 1);
    load(64'h02_00_00_10_A5, 5); xfer(40, -1);
    check("lit_wr_addr", wr_addr, 8'h10);
    check("lit_wr_data", wr_data, 8'hA5);
    check("lit_wel_clr", wel, 0);

    // modes 1-3 write then read back
    for (int m = 1; m < 4; m++) begin
      mode(m);
      load(64'h06, 1); xfer(8, -1);
      load(64'h02_00_00_20_3C, 5); xfer(40, -1);
      load(64'h03_00_00_20_00, 5); xfer(40, -1);
      check("lit_rd_3c", rx_b[4], 8'h3C);
    end

    // burst wrap
    mode(0);
    load(64'h06, 1); xfer(8, -1);
    load(64'h02_00_00_FF_11_22, 6); xfer(48, -1);
    load(64'h03_00_00_FF_00_00, 6); xfer(48, -1);
    check("lit_wrap0", rx_b[4], 8'h11);
    check("lit_wrap1", rx_b[5], 8'h22);

    // write without WREN, unknown opcode
    load(64'h02_00_00_30_55, 5); xfer(40, -1);
    load(64'h9F_00_00, 3); xfer(24, -1);

    // cs_n raised after 5 data bits, then a clean write/read
    mode(1);
    load(64'h06, 1); xfer(8, -1);
    load(64'h02_00_00_40_77, 5); xfer(37, -1);
    load(64'h06, 1); xfer(8, -1);
    load(64'h02_00_00_40_66, 5); xfer(40, -1);
    load(64'h03_00_00_40_00, 5); xfer(40, -1);
    check("lit_rd_66", rx_b[4], 8'h66);

    // reset mid-READ, bus traffic ignored until next cs_n fall
    mode(0);
    load(64'h03_00_00_20_00_00_00, 7); xfer(56, 36);
    load(64'h03_00_00_20_00, 5); xfer(40, -1);
    check("lit_rd_after_rst", rx_b[4], 8'h3C);

    // randomized transactions
    for (int r = 0; r < 16; r++) begin
      mode($urandom_range(0, 3));
      kind = $urandom_range(0, 4);
      a = 8'($urandom_range(0, 7) + 252);
      tx_q.delete();
      nd = 0;
      if (kind == 0) op = 8'h06;
      else if (kind <= 2) begin op = 8'h02; nd = $urandom_range(1, 3); end
      else if (kind == 3) begin op = 8'h03; nd = $urandom_range(1, 3); end
      else begin
        do op = 8'($urandom_range(0, 255)); while (op == 8'h02 || op == 8'h03 || op == 8'h06);
      end
      tx_q.push_back(op);
      if (kind != 0) begin
        tx_q.push_back(8'($urandom_range(0, 255)));
        tx_q.push_back(8'($urandom_range(0, 255)));
        tx_q.push_back(a);
        for (int k = 0; k < nd; k++) tx_q.push_back(8'($urandom_range(0, 255)));
      end
      nb = tx_q.size() * 8;
      if ($urandom_range(0, 3) == 0) nb = nb - $urandom_range(1, 7);
      xfer(nb, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/spi_mem_target.md
# spi_mem_target

SPI target (slave) that answers the flash-style command/address/data transactions our SPI application master issues: 1 instruction byte, 3 address bytes, then data bytes. It holds a local byte-wide memory, supports write-enable, write and read commands in all four CPOL/CPHA modes, and drives MISO back to the master's SIPO. It sits on the far side of the SPI bus as the loop-back target for board bring-up and as the simulation model the master is verified against.

## Interface
- ADDR_BITS, 8: implemented memory address width; depth = 2^ADDR_BITS bytes; upper address bits ignored.
- CLK_SYNC, 2: synchronizer flop stages on sclk, cs_n, mosi.
- clk  in  1  system clock; must be ≥ 8× sclk frequency.
- rst  in  1  reset, asynchronous, active-high; clock clk.
- sclk  in  1  SPI clock from master (asynchronous to clk).
- cs_n  in  1  chip select, active-low.
- mosi  in  1  serial data from master, MSB first.
- cpol  in  1  clock idle level; static while cs_n low.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- miso  out  1  serial data to master, MSB first; 0 when not driving.
- miso_oe  out  1  1 while cs_n low and state is RDATA.
- wel  out  1  write-enable latch status.
- busy  out  1  synchronized cs_n low.
- wr_valid  out  1  one-clk pulse per byte written to memory.
- wr_addr  out  ADDR_BITS  address of last written byte.
- wr_data  out  8  last written byte.
- cmd_err  out  1  one-clk pulse on unknown opcode or WRITE without wel.

## Operation
- sclk, cs_n, mosi pass through CLK_SYNC flops; edges detected on synchronized sclk. Leading edge = rising if cpol=0, falling if cpol=1. Sample edge = leading if cpha=0 else trailing; shift edge is the other.
- Bit counter 0..7 counts sample edges; 8th sample completes a byte. Counter and byte assembly cleared whenever cs_n high.
- Opcodes: 0x06 WREN (sets wel), 0x02 WRITE, 0x03 READ. Any other opcode → cmd_err pulse, state IGNORE.
- States: IDLE → CMD on cs_n fall. CMD byte complete: WREN → IGNORE (wel=1); WRITE with wel=1 → ADDR; WRITE with wel=0 → cmd_err, IGNORE; READ → ADDR. ADDR: three bytes, big-endian, forming 24-bit address; after third byte → WDATA (write) or RDATA (read). IGNORE: consume bits, no action.
- WDATA: each completed byte written to mem[addr], wr_valid/wr_addr/wr_data updated, addr increments modulo 2^ADDR_BITS.
- RDATA: mem[addr] loaded into shift-out register, addr increments after each byte shifted out; wrap modulo 2^ADDR_BITS.
- Any cs_n rise (synchronized) → IDLE from any state; partial byte discarded, no write. If the transaction was a WRITE reaching WDATA, wel clears on that cs_n rise. WREN followed by cs_n rise keeps wel=1.
- miso: cpha=1 → next bit presented on each shift (leading) edge. cpha=0 → MSB presented before first leading edge of the byte, subsequent bits on trailing edges. miso = 0 outside RDATA.
- Memory is not reset; contents are undefined until written.

## Timing
- Reset: state IDLE, wel=0, miso=0, miso_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, cmd_err=0, bit counter 0, synchronizers cleared.
- Input-to-event latency: CLK_SYNC+1 clk from raw sclk edge to internal edge pulse.
- wr_valid and cmd_err assert the clk after the completing sample-edge pulse, for exactly 1 clk.
- RDATA first byte: memory read and shift-out register loaded within 2 clk of the third address byte's completing sample edge, ahead of the next shift edge (guaranteed by the 8× ratio).
- Reset mid-transaction: immediate return to reset values; target ignores bus until next cs_n fall after rst deassert.
- cs_n rise and sample edge in the same clk: cs_n rise wins, byte discarded.

## Test plan
- Mode 0: WREN; WRITE 0x02, addr 00 00 10, data A5 → wr_valid once, wr_addr=0x10, wr_data=0xA5, wel=0 after cs_n rise.
- Modes 1–3: WRITE 0x3C to 0x20, READ 0x03 00 00 20 → MISO byte 0x3C in each mode, miso_oe high only during data byte.
- Burst wrap: WREN, WRITE at 0xFF data 11 22 → mem[0xFF]=0x11, mem[0x00]=0x22; READ from 0xFF two bytes returns 11 22.
- WRITE without WREN → cmd_err pulse, no wr_valid; opcode 0x9F → cmd_err, MISO stays 0.
- cs_n raised after 5 data bits → no write, next transaction decodes correctly; rst asserted mid-READ → all outputs at reset values, next READ correct.
